// File: rtl/wb_arbiter.sv
// Writeback arbiter: two requester FIFOs feeding a single register-file
// write port, with a pending-register mask for hazard detection.
// Optional feature: define WB_ROUND_ROBIN_EN for round-robin arbitration;
// without it requester 0 has fixed priority.
module wb_arbiter #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [4:0]        req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [4:0]        req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              RegWrite,
  output logic [4:0]        rd,
  output logic [DATA_W-1:0] WriteData,
  output logic [31:0]       pending_mask
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  // Per-requester queue storage and bookkeeping, indexed by requester.
  logic [4:0]        q_rd   [2][FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [2][FIFO_DEPTH];
  logic [AW-1:0]     wptr   [2];
  logic [AW-1:0]     rptr   [2];
  logic [CW-1:0]     count  [2];

  logic              in_valid [2];
  logic [4:0]        in_rd    [2];
  logic [DATA_W-1:0] in_data  [2];
  logic              ready    [2];
  logic              push     [2];
  logic              pop      [2];
  logic              nonempty [2];

  logic              sel;
  logic              any_pop;
  logic [4:0]        head_rd;
  logic [DATA_W-1:0] head_data;

  // Gather the two requester ports into arrays so queue logic is written once.
  always_comb begin
    in_valid[0] = req0_valid;
    in_rd[0]    = req0_rd;
    in_data[0]  = req0_data;
    in_valid[1] = req1_valid;
    in_rd[1]    = req1_rd;
    in_data[1]  = req1_data;
  end

  // Ready reflects stored occupancy only; a same-cycle pop does not free a slot.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      nonempty[n] = (count[n] != '0);
      ready[n]    = (count[n] < CW'(FIFO_DEPTH)) && !reset;
      push[n]     = in_valid[n] && ready[n];
    end
  end

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];

`ifdef WB_ROUND_ROBIN_EN
  typedef enum logic {GRANT0 = 1'b0, GRANT1 = 1'b1} grant_e;
  grant_e last_grant;

  // Round-robin: under contention favour the requester not served last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
    sel = 1'b0;
    if (nonempty[0] && nonempty[1]) begin
      sel = (last_grant == GRANT1) ? 1'b0 : 1'b1;
    end else begin
      sel = nonempty[1];
    end
  end

  // Remember who was served; reset points at requester 1 so requester 0 goes first.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GRANT1;
    end else if (any_pop) begin
      last_grant <= grant_e'(sel);
    end
  end
`else
  // Fixed priority: requester 0 wins whenever it has anything queued.
  always_comb begin
    sel = !nonempty[0];
  end
`endif

  // Pop the granted head when at least one queue holds an entry.
  always_comb begin
    any_pop   = nonempty[0] || nonempty[1];
    pop[0]    = any_pop && (sel == 1'b0);
    pop[1]    = any_pop && (sel == 1'b1);
    head_rd   = q_rd[sel][rptr[sel]];
    head_data = q_data[sel][rptr[sel]];
  end

  // Queue pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        wptr[n]  <= '0;
        rptr[n]  <= '0;
        count[n] <= '0;
      end else begin
        if (push[n]) wptr[n] <= wptr[n] + AW'(1);
        if (pop[n])  rptr[n] <= rptr[n] + AW'(1);
        case ({push[n], pop[n]})
          2'b10:   count[n] <= count[n] + CW'(1);
          2'b01:   count[n] <= count[n] - CW'(1);
          default: count[n] <= count[n];
        endcase
      end
    end
  end

  // Entry storage; contents are only observed through the occupancy window.
  always_ff @(posedge clk) begin
    // NOTE: queue storage is deliberately not reset; clearing the pointers and counts is enough to discard it.
    for (int n = 0; n < 2; n++) begin
      if (push[n]) begin
        q_rd[n][wptr[n]]   <= in_rd[n];
        q_data[n][wptr[n]] <= in_data[n];
      end
    end
  end

  // Registered write port; x0 entries are consumed silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite  <= 1'b0;
      rd        <= '0;
      WriteData <= '0;
    end else if (any_pop && (head_rd != 5'd0)) begin
      RegWrite  <= 1'b1;
      rd        <= head_rd;
      WriteData <= head_data;
    end else begin
      RegWrite  <= 1'b0;
      rd        <= '0;
      WriteData <= '0;
    end
  end

  // Pending mask: every live queue entry plus the write currently presented.
  always_comb begin
    logic [AW-1:0] off;
    pending_mask = '0;
    off          = '0;
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        off = AW'(i) - rptr[n];
        if ({1'b0, off} < count[n]) begin
          pending_mask[q_rd[n][i]] = 1'b1;
        end
      end
    end
    if (RegWrite) begin
      pending_mask[rd] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a queue-level reference model predicts
// each retirement (register, data, cycle), a monitor compares outputs.
module tb_wb_arbiter;

  localparam int DW    = 64;
  localparam int DEPTH = 2;

  logic          clk;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic [4:0]    req0_rd, req1_rd;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          RegWrite;
  logic [4:0]    rd;
  logic [DW-1:0] WriteData;
  logic [31:0]   pending_mask;

  wb_arbiter #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .RegWrite(RegWrite), .rd(rd), .WriteData(WriteData), .pending_mask(pending_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct {
    int            cyc;
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } exp_t;

  ent_t m_q0[$];
  ent_t m_q1[$];
  exp_t sb[$];
  int   cyc;
  bit   m_out_v;
  logic [4:0] m_out_rd;
  int   m_last;
  int   checks;
  int   failures;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  // Reference model: two plain queues and the arbitration rule, advanced per edge.
  always @(posedge clk) begin
    bit   acc0, acc1;
    int   g;
    ent_t e;
    cyc++;
    if (reset) begin
      m_q0.delete();
      m_q1.delete();
      m_out_v  = 1'b0;
      m_out_rd = '0;
      m_last   = 1;
    end else begin
      acc0 = req0_valid && (m_q0.size() < DEPTH);
      acc1 = req1_valid && (m_q1.size() < DEPTH);
      g = -1;
      if (m_q0.size() > 0 && m_q1.size() > 0) begin
`ifdef WB_ROUND_ROBIN_EN
        g = (m_last == 1) ? 0 : 1;
`else
        g = 0;
`endif
      end else if (m_q0.size() > 0) begin
        g = 0;
      end else if (m_q1.size() > 0) begin
        g = 1;
      end
      m_out_v  = 1'b0;
      m_out_rd = '0;
      if (g >= 0) begin
        m_last = g;
        e = (g == 0) ? m_q0.pop_front() : m_q1.pop_front();
        if (e.rd != 5'd0) begin
          m_out_v  = 1'b1;
          m_out_rd = e.rd;
          sb.push_back('{cyc: cyc, rd: e.rd, data: e.data});
        end
      end
      if (acc0) m_q0.push_back('{rd: req0_rd, data: req0_data});
      if (acc1) m_q1.push_back('{rd: req1_rd, data: req1_data});
    end
  end

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (m_q0[i]) m[m_q0[i].rd] = 1'b1;
    foreach (m_q1[i]) m[m_q1[i].rd] = 1'b1;
    if (m_out_v) m[m_out_rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // Monitor: sample mid-cycle, compare ready/mask each cycle and retire writes from the scoreboard.
  always @(negedge clk) begin
    exp_t x;
    if (cyc > 0) begin
      check("req0_ready", req0_ready, !reset && (m_q0.size() < DEPTH));
      check("req1_ready", req1_ready, !reset && (m_q1.size() < DEPTH));
      check("pending_mask", pending_mask, model_mask());
      if (RegWrite) begin
        if (sb.size() == 0) begin
          check("unexpected_write_rd", rd, 0);
        end else begin
          x = sb.pop_front();
          check("write_rd", rd, x.rd);
          check("write_data", WriteData, x.data);
          check("write_cycle", cyc, x.cyc);
        end
      end else begin
        check("idle_rd", rd, 0);
        check("idle_data", WriteData, 0);
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          check("regwrite_missing", RegWrite, 1);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit v0, input logic [4:0] r0, input logic [DW-1:0] d0,
                       input bit v1, input logic [4:0] r1, input logic [DW-1:0] d1);
    req0_valid = v0; req0_rd = r0; req0_data = d0;
    req1_valid = v1; req1_rd = r1; req1_data = d1;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 5'd0, '0, 0, 5'd0, '0);
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    m_out_v = 1'b0; m_out_rd = '0; m_last = 1;
    reset = 1'b1;
    // Garbage offered during reset must be discarded.
    drive(1, 5'd7, 64'hdead, 1, 5'd8, 64'hbeef);
    drive(1, 5'd7, 64'hdead, 1, 5'd8, 64'hbeef);
    reset = 1'b0;
    idle(2);

    // Single write to x9.
    drive(1, 5'd9, 64'h99, 0, 5'd0, '0);
    idle(4);

    // Contention: two entries per requester.
    drive(1, 5'd1, 64'h101, 1, 5'd3, 64'h303);
    drive(1, 5'd2, 64'h202, 1, 5'd4, 64'h404);
    idle(6);

    // Back-pressure: requester 0 saturating, requester 1 held valid.
    for (int i = 0; i < 6; i++) drive(1, 5'(5 + i), 64'(i), 1, 5'(20 + i), 64'(100 + i));
    idle(8);

    // Write to x0 is consumed silently.
    drive(1, 5'd0, 64'hffff, 0, 5'd0, '0);
    idle(4);

    // Reset mid-stream with entries queued.
    drive(1, 5'd11, 64'hb1, 1, 5'd12, 64'hc1);
    drive(1, 5'd13, 64'hb2, 1, 5'd14, 64'hc2);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(5);

    // Ten back-to-back writes exercising pointer wrap.
    for (int i = 1; i <= 10; i++) drive(1, 5'(i), 64'(i * 'h11), 0, 5'd0, '0);
    idle(6);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) != 0, 5'($urandom), {$urandom, $urandom},
            $urandom_range(0, 2) != 0, 5'($urandom), {$urandom, $urandom});
    end
    reset = 1'b0;
    idle(20);

    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning writeback data width in bits.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 2, meaning entries per requester queue (power of two, >=2).
REQ-003 The block SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have ports req0_valid / req1_valid  input  1  requester n offers a write.
REQ-006 The block SHALL have ports req0_rd / req1_rd  input  5  destination register index.
REQ-007 The block SHALL have ports req0_data / req1_data  input  DATA_W  write value.
REQ-008 The block SHALL have ports req0_ready / req1_ready  output  1  requester n queue can accept.
REQ-009 The block SHALL have port RegWrite  output  1  register-file write enable.
REQ-010 The block SHALL have port rd  output  5  register-file write index.
REQ-011 The block SHALL have port WriteData  output  DATA_W  register-file write value.
REQ-012 The block SHALL have port pending_mask  output  32  bit r set while a write to register r is queued or presented.

Function
REQ-013 The block SHALL accept a request on requester n at a rising edge where reqN_valid and reqN_ready are both 1, storing {rd, data} in that requester's FIFO.
REQ-014 reqN_ready SHALL be 1 exactly when FIFO n holds fewer than FIFO_DEPTH entries and reset is 0; a pop in the same cycle SHALL NOT raise ready (no pass-through).
REQ-015 Each cycle the block SHALL select at most one non-empty FIFO per REQ-025/REQ-026, pop its head, and register it onto RegWrite/rd/WriteData at the next edge.
REQ-016 RegWrite SHALL be high for exactly one cycle per popped entry with rd != 0; otherwise RegWrite, rd and WriteData SHALL be 0.
REQ-017 Entries with rd = 0 SHALL be accepted and popped normally but SHALL produce RegWrite = 0 and SHALL NOT set pending_mask bit 0.
REQ-018 Minimum latency SHALL be 2 cycles: accepted at edge N, RegWrite high in the cycle following edge N+1.
REQ-019 Writes from one requester SHALL retire in acceptance order; no ordering SHALL be guaranteed between requesters.
REQ-020 Sustained throughput SHALL be one write per cycle while any FIFO is non-empty.
REQ-021 pending_mask bit r (r != 0) SHALL be the OR over all valid FIFO entries and the registered output stage of (entry rd == r); it is combinational from internal state only.
REQ-022 Simultaneous accept and pop on the same FIFO SHALL leave its occupancy unchanged.
REQ-023 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH without losing or duplicating entries.
REQ-024 Inputs reqN_rd/reqN_data SHALL be ignored when reqN_valid = 0 or reqN_ready = 0.

Configuration
REQ-025 With macro WB_ROUND_ROBIN_EN defined, when both FIFOs are non-empty the block SHALL grant the requester not granted most recently; a single non-empty FIFO SHALL be granted regardless of history.
REQ-026 Without WB_ROUND_ROBIN_EN, requester 0 SHALL win whenever its FIFO is non-empty (fixed priority); the last-grant state SHALL be absent.

Reset
REQ-027 At an edge with reset = 1, both FIFOs SHALL be emptied, RegWrite, rd, WriteData SHALL become 0, and the last-grant pointer SHALL point to requester 1 (so requester 0 wins first).
REQ-028 While reset = 1, req0_ready, req1_ready SHALL be 0 and pending_mask SHALL be 0 from the first reset edge; requests offered during reset SHALL be discarded.
REQ-029 Reset asserted mid-operation SHALL drop all queued entries with no RegWrite pulse for them; ready SHALL return to 1 in the first cycle after reset deasserts.

Verification
REQ-030 Single write: req0 {rd=9, data=0x99} at edge 1 -> RegWrite=1, rd=9, WriteData=0x99 for one cycle after edge 2; pending_mask bit 9 set after edge 1, clear after edge 3.
REQ-031 Contention (RR on): both FIFOs loaded with 2 entries each (req0 rd=1,2; req1 rd=3,4) -> output order rd 1,3,2,4 on consecutive cycles; RR off -> 1,2,3,4.
REQ-032 Back-pressure: hold req1_valid, no pops possible (req0 saturating, fixed priority) -> req1_ready drops to 0 after 2 accepts; no third entry stored.
REQ-033 x0: req0 {rd=0, data=0xFFFF} -> entry consumed, RegWrite stays 0, pending_mask stays 0.
REQ-034 Reset mid-stream: 3 entries queued, reset for 1 cycle -> no RegWrite pulse, pending_mask=0, both ready=1 the cycle after release.
REQ-035 Wrap: 10 back-to-back writes from req0 (rd=1..10, data=rd*0x11) -> all 10 retire in order, one per cycle after initial latency.
